// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
//
// Time-of-day counter kept as packed BCD hh:mm:ss. The counter advances on the
// one-cycle seconds strobe while in RUN. It also provides a validated
// time-set handshake and single-cycle carry strobes for the display and alarm
// logic downstream.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_HALT | time held, sec_tick ignored (reset state)
//   ST_RUN  | time advances on each accepted sec_tick
//
// Ports:
//   system_clk  in   single clock, rising edge
//   r           in   synchronous active-low reset
//   sec_tick    in   one-cycle seconds strobe
//   start       in   pulse: enter RUN
//   stop        in   pulse: enter HALT (wins over start)
//   set_valid   in   time-set request
//   set_time    in   {hr, min, sec} packed BCD
//   set_ready   out  set request can be accepted this cycle
//   set_err     out  one-cycle pulse: accepted set_time was invalid
//   hr_bcd      out  hours, BCD
//   min_bcd     out  minutes, BCD
//   sec_bcd     out  seconds, BCD
//   min_carry   out  pulse when seconds wrap 59 -> 00
//   hr_carry    out  pulse when minutes wrap 59 -> 00
//   day_wrap    out  pulse when hours wrap HOURS_MAX -> 00
//   running     out  high in RUN
// ---------------------------------------------------------------------------
module bcd_time_counter #(
  parameter int HOURS_MAX = 23  // 23 or 11
) (
  input  logic        system_clk,
  input  logic        r,
  input  logic        sec_tick,
  input  logic        start,
  input  logic        stop,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  output logic        set_ready,
  output logic        set_err,
  output logic [7:0]  hr_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        min_carry,
  output logic        hr_carry,
  output logic        day_wrap,
  output logic        running
);

  localparam logic [0:0] ST_HALT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [7:0] HR_MAX_BCD = {4'(HOURS_MAX / 10), 4'(HOURS_MAX % 10)};

  logic [0:0] state_q;

  logic       xfer;
  logic       digits_ok;
  logic       tens_ok;
  logic       hour_ok;
  logic       set_ok;
  logic       tick_en;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hr_wrap;
  logic [7:0] sec_nxt;
  logic [7:0] min_nxt;
  logic [7:0] hr_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign xfer = set_valid && set_ready;

  assign digits_ok = (set_time[23:20] <= 4'd9) && (set_time[19:16] <= 4'd9) &&
                     (set_time[15:12] <= 4'd9) && (set_time[11:8]  <= 4'd9) &&
                     (set_time[7:4]   <= 4'd9) && (set_time[3:0]   <= 4'd9);
  assign tens_ok   = (set_time[15:12] <= 4'd5) && (set_time[7:4] <= 4'd5);
  // With both nibbles known to be decimal digits, the packed BCD byte orders
  // the same way as the numeric hour, so a byte compare is enough.
  assign hour_ok   = (set_time[23:16] <= HR_MAX_BCD);
  assign set_ok    = digits_ok && tens_ok && hour_ok;

  // A load in the same cycle drops the tick entirely.
  assign tick_en  = (state_q == ST_RUN) && sec_tick && !xfer;

  assign sec_wrap = (sec_bcd == 8'h59);
  assign min_wrap = (min_bcd == 8'h59);
  assign hr_wrap  = (hr_bcd == HR_MAX_BCD);

  always_comb begin
    sec_nxt = sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
    min_nxt = min_wrap ? 8'h00 : bcd_inc(min_bcd);
    hr_nxt  = hr_wrap  ? 8'h00 : bcd_inc(hr_bcd);
  end

  always_ff @(posedge system_clk) begin
    if (!r) begin
      state_q   <= ST_HALT;
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hr_bcd    <= 8'h00;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      min_carry <= 1'b0;
      hr_carry  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      // ready is consumed for exactly the cycle after a transfer
      set_ready <= !xfer;
      set_err   <= xfer && !set_ok;
      min_carry <= tick_en && sec_wrap;
      hr_carry  <= tick_en && sec_wrap && min_wrap;
      day_wrap  <= tick_en && sec_wrap && min_wrap && hr_wrap;

      if (xfer) begin
        if (set_ok) begin
          hr_bcd  <= set_time[23:16];
          min_bcd <= set_time[15:8];
          sec_bcd <= set_time[7:0];
        end
      end else if (tick_en) begin
        sec_bcd <= sec_nxt;
        if (sec_wrap) begin
          min_bcd <= min_nxt;
        end
        if (sec_wrap && min_wrap) begin
          hr_bcd <= hr_nxt;
        end
      end

      if (stop) begin
        state_q <= ST_HALT;
      end else if (start) begin
        state_q <= ST_RUN;
      end
    end
  end

  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_counter
//
// Self-checking bench for bcd_time_counter. The reference model keeps the
// time as plain seconds-of-day and converts it to BCD only for comparison.
// Directed scenarios come first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_bcd_time_counter;

  localparam int HOURS_MAX = 23;
  localparam int DAY_SECS  = (HOURS_MAX + 1) * 3600;

  logic        system_clk = 1'b0;
  logic        r          = 1'b0;
  logic        sec_tick   = 1'b0;
  logic        start      = 1'b0;
  logic        stop       = 1'b0;
  logic        set_valid  = 1'b0;
  logic [23:0] set_time   = 24'h0;
  logic        set_ready;
  logic        set_err;
  logic [7:0]  hr_bcd;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic        min_carry;
  logic        hr_carry;
  logic        day_wrap;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_t     = 0;
  bit m_run   = 0;
  bit m_ready = 1;
  bit m_err   = 0;
  bit m_mc    = 0;
  bit m_hc    = 0;
  bit m_dw    = 0;

  bcd_time_counter #(.HOURS_MAX(HOURS_MAX)) dut (
    .system_clk(system_clk),
    .r         (r),
    .sec_tick  (sec_tick),
    .start     (start),
    .stop      (stop),
    .set_valid (set_valid),
    .set_time  (set_time),
    .set_ready (set_ready),
    .set_err   (set_err),
    .hr_bcd    (hr_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .min_carry (min_carry),
    .hr_carry  (hr_carry),
    .day_wrap  (day_wrap),
    .running   (running)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] sec_to_bcd(input int t);
    return {to_bcd2(t / 3600), to_bcd2((t / 60) % 60), to_bcd2(t % 60)};
  endfunction

  function automatic bit time_ok(input logic [23:0] v);
    int d [6];
    for (int i = 0; i < 6; i++) d[i] = int'(v[i*4 +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 0;
    if (d[1] > 5 || d[3] > 5) return 0;
    return (d[5] * 10 + d[4]) <= HOURS_MAX;
  endfunction

  function automatic int bcd_to_sec(input logic [23:0] v);
    int h, m, s;
    h = int'(v[23:20]) * 10 + int'(v[19:16]);
    m = int'(v[15:12]) * 10 + int'(v[11:8]);
    s = int'(v[7:4]) * 10 + int'(v[3:0]);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_step(input bit rr, input bit st, input bit sp, input bit tk,
                            input bit sv, input logic [23:0] stime);
    bit xfer;
    if (!rr) begin
      m_t = 0; m_run = 0; m_ready = 1; m_err = 0; m_mc = 0; m_hc = 0; m_dw = 0;
      return;
    end
    xfer  = sv && m_ready;
    m_err = 0; m_mc = 0; m_hc = 0; m_dw = 0;
    if (xfer) begin
      if (time_ok(stime)) m_t = bcd_to_sec(stime);
      else m_err = 1;
    end else if (m_run && tk) begin
      m_mc = (m_t % 60) == 59;
      m_hc = (m_t % 3600) == 3599;
      m_dw = m_t == DAY_SECS - 1;
      m_t  = (m_t + 1) % DAY_SECS;
    end
    m_ready = !xfer;
    if (sp) m_run = 0;
    else if (st) m_run = 1;
  endtask

  // Drive one cycle of inputs, advance the model on the same edge and compare
  // all outputs 1 time unit after that edge.
  task automatic cyc(input bit rr, input bit st, input bit sp, input bit tk,
                     input bit sv, input logic [23:0] stime);
    r = rr; start = st; stop = sp; sec_tick = tk; set_valid = sv; set_time = stime;
    @(posedge system_clk);
    model_step(rr, st, sp, tk, sv, stime);
    #1;
    chk("time", {8'h0, hr_bcd, min_bcd, sec_bcd}, {8'h0, sec_to_bcd(m_t)});
    chk("flags", {26'h0, set_ready, set_err, min_carry, hr_carry, day_wrap, running},
        {26'h0, m_ready, m_err, m_mc, m_hc, m_dw, m_run});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 24'h0);
  endtask

  logic [23:0] bad_vals [3] = '{24'h2A0000, 24'h006000, 24'h240000};

  initial begin
    // reset then run
    cyc(0, 0, 0, 0, 0, 24'h0);
    cyc(0, 0, 0, 0, 0, 24'h0);
    chk("rst_ready", {31'h0, set_ready}, 32'h1);
    chk("rst_running", {31'h0, running}, 32'h0);
    idle(1);
    cyc(1, 1, 0, 0, 0, 24'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 0, 24'h0);
      idle(4);
    end
    chk("run_sec", {24'h0, sec_bcd}, 32'h03);
    chk("run_running", {31'h0, running}, 32'h1);

    // full cascade
    cyc(1, 0, 0, 0, 1, 24'h235959);
    idle(1);
    cyc(1, 1, 0, 0, 0, 24'h0);
    cyc(1, 0, 0, 1, 0, 24'h0);
    chk("casc_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h000000);
    chk("casc_pulses", {29'h0, min_carry, hr_carry, day_wrap}, 32'h7);
    idle(1);
    chk("casc_pulses_end", {29'h0, min_carry, hr_carry, day_wrap}, 32'h0);

    // invalid loads
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 1, bad_vals[i]);
      chk("bad_err", {31'h0, set_err}, 32'h1);
      chk("bad_ready", {31'h0, set_ready}, 32'h0);
      chk("bad_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h000000);
      idle(1);
      chk("bad_err_end", {31'h0, set_err}, 32'h0);
      chk("bad_ready_end", {31'h0, set_ready}, 32'h1);
    end

    // load / tick collision while running
    cyc(1, 0, 0, 0, 1, 24'h120030);
    idle(1);
    cyc(1, 0, 0, 1, 1, 24'h080000);
    chk("coll_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h080000);
    chk("coll_carry", {29'h0, min_carry, hr_carry, day_wrap}, 32'h0);
    idle(1);
    cyc(1, 0, 0, 1, 0, 24'h0);
    chk("coll_next", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h080001);

    // start and stop together in RUN, then tick while halted
    cyc(1, 1, 1, 0, 0, 24'h0);
    chk("ctl_stop_wins", {31'h0, running}, 32'h0);
    cyc(1, 0, 0, 0, 1, 24'h000059);
    idle(1);
    cyc(1, 0, 0, 1, 0, 24'h0);
    chk("halt_hold", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h000059);
    chk("halt_no_carry", {31'h0, min_carry}, 32'h0);

    // reset right after a wrap, with a set request pending
    cyc(1, 0, 0, 0, 1, 24'h115959);
    idle(1);
    cyc(1, 1, 0, 0, 0, 24'h0);
    cyc(1, 0, 0, 1, 0, 24'h0);
    chk("mid_wrap", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h120000);
    chk("mid_wrap_pulses", {29'h0, min_carry, hr_carry, day_wrap}, 32'h6);
    cyc(0, 0, 0, 0, 1, 24'h101010);
    chk("mid_rst_time", {8'h0, hr_bcd, min_bcd, sec_bcd}, 32'h000000);
    chk("mid_rst_flags", {26'h0, set_ready, set_err, min_carry, hr_carry, day_wrap, running},
        32'h20);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      bit rr, st, sp, tk, sv;
      logic [23:0] v;
      int sel;
      rr  = $urandom_range(0, 299) != 0;
      st  = $urandom_range(0, 7) == 0;
      sp  = $urandom_range(0, 19) == 0;
      tk  = $urandom_range(0, 1) == 1;
      sv  = $urandom_range(0, 5) == 0;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0, 1:    v = sec_to_bcd(int'($urandom_range(0, DAY_SECS - 1)));
        2:       v = sec_to_bcd(DAY_SECS - 1 - int'($urandom_range(0, 3)) * 3600
                                - int'($urandom_range(0, 1)) * 60 - int'($urandom_range(0, 2)));
        default: v = 24'($urandom);
      endcase
      cyc(rr, st, sp, tk, sv, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
